// File: rtl/jam_sim_sequencer.sv
// Run controller for the traffic-jam simulation datapath: step strobe generation,
// car launch scheduling, pause/single-step and jam / step-limit termination.
module jam_sim_sequencer #(
  parameter int CLK_DIV    = 5000000,
  parameter int N_CARS     = 30,
  parameter int LAUNCH_GAP = 2,
  parameter int MAX_STEPS  = 200,
  parameter int STEP_W     = 11
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_single,
  input  logic              i_jam,
  output logic              o_clear,
  output logic              o_step,
  output logic              o_launch,
  output logic [4:0]        o_launch_id,
  output logic [STEP_W-1:0] o_step_cnt,
  output logic [1:0]        o_state,
  output logic              o_done,
  output logic [1:0]        o_reason
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(LAUNCH_GAP + 1);
  localparam int CAR_W = 6;

  localparam logic [1:0] REASON_NONE  = 2'b00;
  localparam logic [1:0] REASON_JAM   = 2'b01;
  localparam logic [1:0] REASON_LIMIT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CAR_W-1:0]  car_q, car_d;
  logic              clear_q, clear_d;
  logic              step_q, step_d;
  logic              launch_q, launch_d;
  logic [4:0]        id_q, id_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [1:0]        reason_q, reason_d;
  logic              limit_hit;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    gap_d     = gap_q;
    car_d     = car_q;
    id_d      = id_q;
    reason_d  = reason_q;
    clear_d   = 1'b0;
    step_d    = 1'b0;
    launch_d  = 1'b0;
    // The step counter trails o_step by one cycle; the limit is caught on the
    // final step cycle itself so no further divider fire can slip through.
    cnt_d     = cnt_q + STEP_W'(step_q);
    limit_hit = step_q && (cnt_q == STEP_W'(MAX_STEPS - 1));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d  = S_RUN;
          clear_d  = 1'b1;
          div_d    = '0;
          gap_d    = '0;
          car_d    = '0;
          id_d     = '0;
          cnt_d    = '0;
          reason_d = REASON_NONE;
        end
      end
      S_RUN: begin
        if (i_jam) begin
          state_d  = S_DONE;
          reason_d = REASON_JAM;
        end else if (limit_hit) begin
          state_d  = S_DONE;
          reason_d = REASON_LIMIT;
        end else begin
          if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d  = '0;
            step_d = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
          if (i_pause) state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (i_jam) begin
          state_d  = S_DONE;
          reason_d = REASON_JAM;
        end else if (limit_hit) begin
          state_d  = S_DONE;
          reason_d = REASON_LIMIT;
        end else if (!i_pause) begin
          state_d = S_RUN;
        end else if (i_single && !step_q) begin
          step_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // gap_q counts steps remaining until the next car is due
    if (step_d) begin
      if (gap_q == '0 && car_q < CAR_W'(N_CARS)) begin
        launch_d = 1'b1;
        id_d     = car_q[4:0];
        car_d    = car_q + 1'b1;
        gap_d    = GAP_W'(LAUNCH_GAP - 1);
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      gap_q    <= '0;
      car_q    <= '0;
      clear_q  <= 1'b0;
      step_q   <= 1'b0;
      launch_q <= 1'b0;
      id_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      reason_q <= REASON_NONE;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      car_q    <= car_d;
      clear_q  <= clear_d;
      step_q   <= step_d;
      launch_q <= launch_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      reason_q <= reason_d;
    end
  end

  assign o_clear     = clear_q;
  assign o_step      = step_q;
  assign o_launch    = launch_q;
  assign o_launch_id = id_q;
  assign o_step_cnt  = cnt_q;
  assign o_state     = state_q;
  assign o_done      = done_q;
  assign o_reason    = reason_q;

endmodule

// File: doc/jam_sim_sequencer.md
Name: jam_sim_sequencer

Overview:
Run controller for the traffic-jam simulation datapath.
- Generates the slow simulation step strobe from i_clk.
- Schedules car launches at fixed step intervals.
- Clears the road at run start.
- Supports pause and single-step.
- Halts the run on a jam flag from the datapath or on a step limit. This replaces the free-running internal time counter and stop flag inside the datapath.

Parameters:
- CLK_DIV, 5000000, i_clk cycles per simulation step (>=2)
- N_CARS, 30, number of cars to launch (1..32)
- LAUNCH_GAP, 2, steps between consecutive car launches (>=1)
- MAX_STEPS, 200, step limit; run ends after this many steps
- STEP_W, 11, width of step counter (must hold MAX_STEPS)

Ports:
- i_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  start/restart request, sampled per cycle
- i_pause  in  1  level; freeze stepping while high
- i_single  in  1  pulse; one manual step while paused
- i_jam  in  1  datapath jam-detected flag
- o_clear  out  1  one-cycle pulse; datapath clears positions and outputs
- o_step  out  1  one-cycle pulse; datapath advances one step
- o_launch  out  1  one-cycle pulse, only coincident with o_step; release car o_launch_id on this step
- o_launch_id  out  5  index of car launched
- o_step_cnt  out  STEP_W  steps issued since last start
- o_state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
- o_done  out  1  high in DONE
- o_reason  out  2  00 none, 01 jam, 10 step limit; valid in DONE

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; divider, step counter and launch counter 0.
- All outputs are registered.
- IDLE:
  - i_start=1 -> RUN.
  - o_clear=1 for exactly the first RUN cycle.
  - Divider, step count, launch id and reason are zeroed.
- RUN:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - o_step is high one cycle every CLK_DIV cycles. The first pulse occurs CLK_DIV cycles after the o_clear cycle.
  - o_step_cnt increments in the cycle after each o_step.
- Launch schedule:
  - On a step whose pre-increment count equals n*LAUNCH_GAP, with n < N_CARS: o_launch=1 and o_launch_id=n.
  - No launch once n reaches N_CARS.
  - Launch ids are strictly ascending, with no gaps.
- Pause:
  - i_pause=1 in RUN -> PAUSED next cycle; the divider holds its value.
  - i_pause=0 in PAUSED -> RUN; the divider resumes from the held value.
- Single-step:
  - i_single=1 in PAUSED (i_pause still high) issues exactly one o_step (plus a launch if due) the next cycle.
  - The divider is untouched.
  - i_single is ignored outside PAUSED.
- Jam:
  - i_jam=1 sampled in RUN or PAUSED -> DONE next cycle, o_reason=01.
  - If the divider would fire in the same cycle i_jam is sampled high, no o_step is issued (jam priority over step).
- Step limit:
  - When o_step_cnt reaches MAX_STEPS -> DONE, o_reason=10.
  - No further o_step.
  - Jam and limit in the same cycle -> reason 01.
- DONE:
  - o_done=1; o_step_cnt, o_launch_id and o_reason hold.
  - i_jam is ignored.
  - i_start=1 -> restart exactly as from IDLE (o_clear pulse, counters zeroed, o_reason=00).
- i_start while in RUN or PAUSED is ignored.
- Simultaneous i_pause and i_single in RUN: pause only; the single-step is dropped.
- o_step, o_launch and o_clear are never high for two consecutive cycles. o_clear is never coincident with o_step.

Test Plan:
All scenarios use CLK_DIV=4, N_CARS=4, LAUNCH_GAP=2, MAX_STEPS=10.
1. Reset, pulse i_start -> o_clear high exactly 1 cycle. o_step every 4 cycles thereafter. Launch ids 0,1,2,3 on steps 0,2,4,6; no launch on odd steps or after step 6.
2. Free run, i_jam=0 -> exactly 10 o_step pulses, then o_state=11, o_done=1, o_reason=10, o_step_cnt=10, no further pulses.
3. Jam:
   - Assert i_jam after step 3 -> DONE next cycle, o_reason=01, o_step_cnt=3.
   - Repeat with i_jam rising on the divider-fire cycle -> that o_step is absent.
4. Pause/single-step:
   - Hold i_pause 20 cycles -> no o_step.
   - Two i_single pulses -> exactly 2 steps, o_step_cnt +2, launch emitted if due.
   - Release i_pause -> next o_step after the remaining held divider count.
5. Reset and restart:
   - Assert reset mid-RUN -> all outputs 0 asynchronously, state IDLE.
   - Separately, i_start in DONE -> o_clear pulse, o_step_cnt=0, o_reason=00, launch id restarts at 0.
   - i_start during RUN -> no effect.
